// File: rtl/usb_desc_xfer_ctrl.sv
// usb_desc_xfer_ctrl
// Data-stage sequencer for GET_DESCRIPTOR on EP0. It looks up (type, index) in an
// external directory, reads the descriptor header from the byte ROM, clamps the
// length to wLength, and streams the descriptor as max_pkt-sized IN packets. It
// handles per-packet ACK and retry and sends the terminating zero-length packet.
//
// Ports
//   clk48, rstn          clock, asynchronous active-low reset
//   req_*                request from the EP0 control FSM (req_valid is a 1-cycle pulse)
//   req_abort            SETUP or bus reset; returns to IDLE and wins over every other input
//   max_pkt              EP0 max packet size (8/16/32/64)
//   dir_type/dir_idx     directory key; dir_hit/dir_addr come back combinationally
//   rom_addr/rom_data    byte ROM, rom_data is valid one cycle after rom_addr
//   in_pkt_req           IN token granted; starts the next packet
//   byte_*               payload handshake toward the IN packet engine
//   pkt_done/pkt_len     end-of-packet pulse and byte count (0 = ZLP)
//   in_pkt_ack/_retry    host handshake result for the last packet
//   busy/stall/xfer_done status
//
// Optional build macro: USB_DESC_LANGID_CHECK_EN stalls STRING requests with a
// non-zero index whose wIndex differs from LANGID. String index 0 is always served.
//
// State      | meaning
// IDLE       | no transfer in progress
// LOOKUP     | directory keyed by the latched request
// HDR_LEN    | bLength on rom_data
// HDR_TL0    | wTotalLength low byte on rom_data (configuration only)
// HDR_TL1    | wTotalLength high byte on rom_data (configuration only)
// WAIT_IN    | waiting for an IN token
// FETCH      | ROM read of the current byte in flight
// PRESENT    | byte offered to the packet engine
// WAIT_ACK   | packet sent, waiting for ACK or retry
// STALLED    | request unsupported
module usb_desc_xfer_ctrl #(
  parameter int unsigned ROM_AW = 10,
  parameter logic [15:0] LANGID = 16'h0409
) (
  input  logic              clk48,
  input  logic              rstn,
  input  logic              req_valid,
  input  logic [7:0]        req_type,
  input  logic [7:0]        req_idx,
  input  logic [15:0]       req_wlength,
  input  logic [15:0]       req_langid,
  input  logic              req_abort,
  input  logic [7:0]        max_pkt,
  output logic [7:0]        dir_type,
  output logic [7:0]        dir_idx,
  input  logic              dir_hit,
  input  logic [ROM_AW-1:0] dir_addr,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  input  logic              in_pkt_req,
  output logic              byte_valid,
  output logic [7:0]        byte_data,
  input  logic              byte_ready,
  output logic              byte_last,
  output logic              pkt_done,
  output logic [6:0]        pkt_len,
  input  logic              in_pkt_ack,
  input  logic              in_pkt_retry,
  output logic              busy,
  output logic              stall,
  output logic              xfer_done
);

  localparam logic [7:0] DESC_CONFIGURATION = 8'd2;
  localparam logic [7:0] DESC_STRING        = 8'd3;

  typedef enum logic [3:0] {
    IDLE, LOOKUP, HDR_LEN, HDR_TL0, HDR_TL1, WAIT_IN, FETCH, PRESENT, WAIT_ACK, STALLED
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        type_q, idx_q, tl_lo_q;
  logic [15:0]       wlen_q, remain_q, remain_save_q;
  logic [ROM_AW-1:0] cur_q, pkt_start_q;
  logic [6:0]        cnt_q, pkt_len_q;
  logic              zlp_pend_q, pkt_done_q, xfer_done_q;

  logic [15:0]       desc_len_c, remain_c, mask_c;
  logic              zlp_c, last_c, ack_done_c, lang_bad;

`ifdef USB_DESC_LANGID_CHECK_EN
  logic [15:0] langid_q;

  always_ff @(posedge clk48 or negedge rstn) begin
    if (!rstn)          langid_q <= '0;
    else if (req_valid) langid_q <= req_langid;
  end

  assign lang_bad = (type_q == DESC_STRING) && (idx_q != 8'd0) && (langid_q != LANGID);
`else
  logic unused_langid;
  assign unused_langid = ^{req_langid, LANGID};
  assign lang_bad      = 1'b0;
`endif

  // Length comes from bLength, or from wTotalLength once its high byte is on rom_data.
  assign desc_len_c = (state_q == HDR_TL1) ? {rom_data, tl_lo_q} : {8'h00, rom_data};
  assign remain_c   = (desc_len_c < wlen_q) ? desc_len_c : wlen_q;
  assign mask_c     = {8'h00, max_pkt - 8'd1};
  // wLength = 0 behaves as a status-only transfer: a single ZLP.
  assign zlp_c      = (wlen_q == 16'd0) ||
                      ((desc_len_c < wlen_q) && ((remain_c & mask_c) == 16'd0));
  assign last_c     = (({1'b0, cnt_q} + 8'd1) == max_pkt) || (remain_q == 16'd1);
  // A pending ZLP is satisfied once a zero-length packet itself gets ACKed.
  assign ack_done_c = (remain_q == 16'd0) && (!zlp_pend_q || (pkt_len_q == 7'd0));

  always_ff @(posedge clk48 or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    rom_addr   = '0;
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    byte_data  = 8'h00;
    unique case (state_q)
      IDLE:     if (req_valid) state_d = LOOKUP;
      LOOKUP: begin
        rom_addr = dir_addr;
        state_d  = (!dir_hit || lang_bad) ? STALLED : HDR_LEN;
      end
      HDR_LEN: begin
        rom_addr = cur_q + ROM_AW'(2);
        state_d  = (type_q == DESC_CONFIGURATION) ? HDR_TL0 : WAIT_IN;
      end
      HDR_TL0: begin
        rom_addr = cur_q + ROM_AW'(3);
        state_d  = HDR_TL1;
      end
      HDR_TL1:  state_d = WAIT_IN;
      WAIT_IN:  if (in_pkt_req) state_d = (remain_q == 16'd0) ? WAIT_ACK : FETCH;
      FETCH: begin
        rom_addr = cur_q;
        state_d  = PRESENT;
      end
      PRESENT: begin
        // Address held so rom_data stays stable while the engine back-pressures.
        rom_addr   = cur_q;
        byte_valid = 1'b1;
        byte_data  = rom_data;
        byte_last  = last_c;
        if (byte_ready) state_d = last_c ? WAIT_ACK : FETCH;
      end
      WAIT_ACK: begin
        if (in_pkt_ack)        state_d = ack_done_c ? IDLE : WAIT_IN;
        else if (in_pkt_retry) state_d = WAIT_IN;
      end
      STALLED:  state_d = state_q;
      default:  state_d = IDLE;
    endcase
    if (req_valid) state_d = LOOKUP;
    if (req_abort) state_d = IDLE;
  end

  always_ff @(posedge clk48 or negedge rstn) begin
    if (!rstn) begin
      type_q        <= '0;
      idx_q         <= '0;
      wlen_q        <= '0;
      tl_lo_q       <= '0;
      remain_q      <= '0;
      remain_save_q <= '0;
      cur_q         <= '0;
      pkt_start_q   <= '0;
      cnt_q         <= '0;
      zlp_pend_q    <= 1'b0;
      pkt_done_q    <= 1'b0;
      pkt_len_q     <= '0;
      xfer_done_q   <= 1'b0;
    end else if (req_abort) begin
      type_q      <= '0;
      idx_q       <= '0;
      pkt_done_q  <= 1'b0;
      pkt_len_q   <= '0;
      xfer_done_q <= 1'b0;
    end else begin
      pkt_done_q  <= 1'b0;
      xfer_done_q <= 1'b0;
      if (req_valid) begin
        type_q <= req_type;
        idx_q  <= req_idx;
        wlen_q <= req_wlength;
      end else begin
        unique case (state_q)
          LOOKUP:  cur_q <= dir_addr;
          HDR_LEN: begin
            if (type_q != DESC_CONFIGURATION) begin
              remain_q   <= remain_c;
              zlp_pend_q <= zlp_c;
            end
          end
          HDR_TL0: tl_lo_q <= rom_data;
          HDR_TL1: begin
            remain_q   <= remain_c;
            zlp_pend_q <= zlp_c;
          end
          WAIT_IN: begin
            if (in_pkt_req) begin
              pkt_start_q   <= cur_q;
              remain_save_q <= remain_q;
              cnt_q         <= '0;
              if (remain_q == 16'd0) begin
                pkt_done_q <= 1'b1;
                pkt_len_q  <= '0;
              end
            end
          end
          PRESENT: begin
            if (byte_ready) begin
              cur_q    <= cur_q + ROM_AW'(1);
              remain_q <= remain_q - 16'd1;
              cnt_q    <= cnt_q + 7'd1;
              if (last_c) begin
                pkt_done_q <= 1'b1;
                pkt_len_q  <= cnt_q + 7'd1;
              end
            end
          end
          WAIT_ACK: begin
            if (in_pkt_ack) begin
              if (ack_done_c) xfer_done_q <= 1'b1;
            end else if (in_pkt_retry) begin
              cur_q    <= pkt_start_q;
              remain_q <= remain_save_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign dir_type  = type_q;
  assign dir_idx   = idx_q;
  assign pkt_done  = pkt_done_q;
  assign pkt_len   = pkt_len_q;
  assign xfer_done = xfer_done_q;
  assign busy      = (state_q != IDLE);
  assign stall     = (state_q == STALLED);

endmodule

// File: tb/tb_usb_desc_xfer_ctrl.sv
// Bench for usb_desc_xfer_ctrl: synchronous byte ROM and directory models, an IN
// packet engine with random back-pressure, and a packet-list reference model.
module tb_usb_desc_xfer_ctrl;
  localparam int ROM_SZ = 1024;

  logic        clk48, rstn;
  logic        req_valid, req_abort;
  logic [7:0]  req_type, req_idx, max_pkt;
  logic [15:0] req_wlength, req_langid;
  logic [7:0]  dir_type, dir_idx;
  logic        dir_hit;
  logic [9:0]  dir_addr, rom_addr;
  logic [7:0]  rom_data;
  logic        in_pkt_req, byte_valid, byte_ready, byte_last, pkt_done;
  logic [7:0]  byte_data;
  logic [6:0]  pkt_len;
  logic        in_pkt_ack, in_pkt_retry, busy, stall, xfer_done;

  usb_desc_xfer_ctrl #(.ROM_AW(10), .LANGID(16'h0409)) dut (
    .clk48(clk48), .rstn(rstn), .req_valid(req_valid), .req_type(req_type),
    .req_idx(req_idx), .req_wlength(req_wlength), .req_langid(req_langid),
    .req_abort(req_abort), .max_pkt(max_pkt), .dir_type(dir_type), .dir_idx(dir_idx),
    .dir_hit(dir_hit), .dir_addr(dir_addr), .rom_addr(rom_addr), .rom_data(rom_data),
    .in_pkt_req(in_pkt_req), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .byte_last(byte_last), .pkt_done(pkt_done), .pkt_len(pkt_len),
    .in_pkt_ack(in_pkt_ack), .in_pkt_retry(in_pkt_retry), .busy(busy), .stall(stall),
    .xfer_done(xfer_done)
  );

  initial clk48 = 1'b0;
  always #5 clk48 = ~clk48;

  logic [7:0] rom [ROM_SZ];
  always @(posedge clk48) rom_data <= rom[rom_addr];

  logic [7:0] d_type [8];
  logic [7:0] d_idx  [8];
  logic [9:0] d_addr [8];
  always_comb begin
    dir_hit  = 1'b0;
    dir_addr = '0;
    for (int i = 0; i < 8; i++)
      if (d_type[i] == dir_type && d_idx[i] == dir_idx) begin
        dir_hit  = 1'b1;
        dir_addr = d_addr[i];
      end
  end

  int n_checks = 0, n_pass = 0, n_fail = 0;
  int exp_lens[$];
  logic [7:0] got_b[$];
  bit got_l[$];
  logic [7:0] mp_tab [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk48);
  endtask

  function automatic logic [7:0] romb(input int a);
    logic [9:0] ai;
    ai = 10'(a % ROM_SZ);
    return rom[ai];
  endfunction

  // Expected packet sizes from the descriptor length, wLength and max packet size.
  task automatic model(input logic [7:0] t, input int base, input int wl, input int mp);
    int dl, total, off, n;
    exp_lens.delete();
    if (t == 8'd2) dl = int'(romb(base + 3)) * 256 + int'(romb(base + 2));
    else           dl = int'(romb(base));
    total = (dl < wl) ? dl : wl;
    off = 0;
    while (off < total) begin
      n = total - off;
      if (n > mp) n = mp;
      exp_lens.push_back(n);
      off += n;
    end
    if (wl == 0 || (dl < wl && total % mp == 0)) exp_lens.push_back(0);
  endtask

  task automatic send_req(input logic [7:0] t, input logic [7:0] i, input logic [15:0] wl,
                          input logic [15:0] lid);
    req_type = t; req_idx = i; req_wlength = wl; req_langid = lid;
    req_valid = 1'b1;
    cyc(1);
    req_valid = 1'b0;
  endtask

  task automatic recv_pkt(output int len, output bit seen);
    got_b.delete();
    got_l.delete();
    seen = 1'b0;
    len  = 0;
    in_pkt_req = 1'b1;
    cyc(1);
    in_pkt_req = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (pkt_done) begin
        seen = 1'b1;
        len  = int'(pkt_len);
        break;
      end
      if (byte_valid) begin
        byte_ready = ($urandom_range(0, 3) != 0);
        if (byte_ready) begin
          got_b.push_back(byte_data);
          got_l.push_back(byte_last);
        end
      end else byte_ready = 1'b0;
      cyc(1);
    end
    byte_ready = 1'b0;
  endtask

  task automatic do_xfer(input logic [7:0] t, input logic [7:0] i, input int wl,
                         input logic [15:0] lid, input logic [7:0] mp, input int base,
                         input int retry_at, input int both_at);
    int len, off, tries, last;
    bit seen;
    max_pkt = mp;
    model(t, base, wl, int'(mp));
    send_req(t, i, 16'(wl), lid);
    cyc(6);
    off  = 0;
    last = exp_lens.size() - 1;
    for (int p = 0; p <= last; p++) begin
      tries = (p == retry_at) ? 2 : 1;
      for (int r = 0; r < tries; r++) begin
        recv_pkt(len, seen);
        chk("pkt_seen", 32'(seen), 32'd1);
        chk("pkt_len", 32'(len), 32'(exp_lens[p]));
        chk("pkt_nbytes", 32'(got_b.size()), 32'(exp_lens[p]));
        for (int k = 0; k < got_b.size() && k < exp_lens[p]; k++) begin
          chk("byte", 32'(got_b[k]), 32'(romb(base + off + k)));
          chk("byte_last", 32'(got_l[k]), 32'(k == exp_lens[p] - 1));
        end
        if (r < tries - 1) begin
          in_pkt_retry = 1'b1;
          cyc(1);
          in_pkt_retry = 1'b0;
          chk("retry_busy", 32'(busy), 32'd1);
        end
      end
      in_pkt_ack = 1'b1;
      if (p == both_at) in_pkt_retry = 1'b1;
      cyc(1);
      in_pkt_ack = 1'b0;
      in_pkt_retry = 1'b0;
      chk("xfer_done", 32'(xfer_done), 32'(p == last));
      off += exp_lens[p];
    end
    chk("busy_end", 32'(busy), 32'd0);
    cyc(1);
    chk("xfer_done_pulse", 32'(xfer_done), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel, wl, base, tl;
    logic [7:0] t;
    rstn = 1'b0; req_valid = 1'b0; req_abort = 1'b0; req_type = '0; req_idx = '0;
    req_wlength = '0; req_langid = '0; max_pkt = 8'd8; in_pkt_req = 1'b0;
    byte_ready = 1'b0; in_pkt_ack = 1'b0; in_pkt_retry = 1'b0;
    mp_tab[0] = 8'd8; mp_tab[1] = 8'd16; mp_tab[2] = 8'd32; mp_tab[3] = 8'd64;
    for (int k = 0; k < ROM_SZ; k++) rom[k] = 8'($urandom);
    for (int k = 0; k < 8; k++) begin
      d_type[k] = 8'hFF; d_idx[k] = 8'hFF; d_addr[k] = '0;
    end
    d_type[0] = 8'd1; d_idx[0] = 8'd0; d_addr[0] = 10'd100;
    d_type[1] = 8'd2; d_idx[1] = 8'd0; d_addr[1] = 10'd200;
    d_type[2] = 8'd3; d_idx[2] = 8'd1; d_addr[2] = 10'd400;
    d_type[3] = 8'd3; d_idx[3] = 8'd0; d_addr[3] = 10'd450;
    d_type[4] = 8'd2; d_idx[4] = 8'd1; d_addr[4] = 10'd1020;
    cyc(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_byte_valid", 32'(byte_valid), 32'd0);
    chk("rst_pkt_done", 32'(pkt_done), 32'd0);
    chk("rst_xfer_done", 32'(xfer_done), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_dir_type", 32'(dir_type), 32'd0);
    chk("rst_dir_idx", 32'(dir_idx), 32'd0);
    rstn = 1'b1;
    cyc(2);

    // Device 18 bytes, wLength 64, mp 8: 8, 8, 2.
    rom[100] = 8'd18;
    do_xfer(8'd1, 8'd0, 64, 16'h0, 8'd8, 100, -1, -1);
    // Configuration 32 bytes, wLength 255, mp 16: 16, 16, ZLP.
    rom[202] = 8'd32; rom[203] = 8'd0;
    do_xfer(8'd2, 8'd0, 255, 16'h0, 8'd16, 200, -1, -1);
    // Configuration 32 bytes, wLength 9, mp 8: 8, 1.
    do_xfer(8'd2, 8'd0, 9, 16'h0, 8'd8, 200, -1, -1);
    // Retry after first packet, ack+retry on the second.
    do_xfer(8'd1, 8'd0, 64, 16'h0, 8'd8, 100, 0, 1);
    // wLength 0: single ZLP.
    do_xfer(8'd1, 8'd0, 0, 16'h0, 8'd8, 100, -1, -1);
    // ROM address wrap across the top of the ROM.
    rom[1022] = 8'd20; rom[1023] = 8'd0;
    do_xfer(8'd2, 8'd1, 100, 16'h0, 8'd8, 1020, -1, -1);

    // Directory miss: stall held, no bytes; abort clears.
    send_req(8'd5, 8'd0, 16'd64, 16'h0);
    cyc(2);
    in_pkt_req = 1'b1;
    cyc(1);
    in_pkt_req = 1'b0;
    cyc(2);
    chk("miss_stall", 32'(stall), 32'd1);
    chk("miss_no_byte", 32'(byte_valid), 32'd0);
    chk("miss_busy", 32'(busy), 32'd1);
    req_abort = 1'b1;
    cyc(1);
    req_abort = 1'b0;
    chk("abort_stall", 32'(stall), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);

    // Abort while a byte is held by back-pressure.
    max_pkt = 8'd8;
    send_req(8'd1, 8'd0, 16'd64, 16'h0);
    cyc(6);
    in_pkt_req = 1'b1;
    cyc(1);
    in_pkt_req = 1'b0;
    cyc(3);
    chk("hold_valid", 32'(byte_valid), 32'd1);
    chk("hold_data", 32'(byte_data), 32'(rom[100]));
    req_abort = 1'b1;
    cyc(1);
    req_abort = 1'b0;
    chk("abort2_busy", 32'(busy), 32'd0);
    chk("abort2_valid", 32'(byte_valid), 32'd0);
    chk("abort2_dir_type", 32'(dir_type), 32'd0);
    chk("abort2_rom_addr", 32'(rom_addr), 32'd0);
    in_pkt_req = 1'b1;
    cyc(1);
    in_pkt_req = 1'b0;
    cyc(1);
    chk("idle_in_req_ignored", 32'(busy), 32'd0);
    chk("idle_no_pkt_done", 32'(pkt_done), 32'd0);

    // String index 1 with a foreign language ID.
    rom[400] = 8'd10;
`ifdef USB_DESC_LANGID_CHECK_EN
    send_req(8'd3, 8'd1, 16'd64, 16'h0407);
    cyc(3);
    chk("lang_stall", 32'(stall), 32'd1);
    chk("lang_no_byte", 32'(byte_valid), 32'd0);
    req_abort = 1'b1;
    cyc(1);
    req_abort = 1'b0;
    chk("lang_abort", 32'(stall), 32'd0);
`else
    do_xfer(8'd3, 8'd1, 64, 16'h0407, 8'd8, 400, -1, -1);
`endif
    do_xfer(8'd3, 8'd1, 64, 16'h0409, 8'd8, 400, -1, -1);
    rom[450] = 8'd4;
    do_xfer(8'd3, 8'd0, 64, 16'h0407, 8'd8, 450, -1, -1);

    // Randomized transfers.
    for (int it = 0; it < 8; it++) begin
      sel = int'($urandom_range(0, 2));
      wl  = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 160));
      tl  = int'($urandom_range(0, 150));
      if (sel == 0) begin
        t = 8'd1; base = 100; rom[100] = 8'($urandom_range(0, 80));
      end else if (sel == 1) begin
        t = 8'd2; base = 200; rom[202] = 8'(tl); rom[203] = 8'(tl >> 8);
      end else begin
        t = 8'd2; base = 1020; rom[1022] = 8'(tl); rom[1023] = 8'(tl >> 8);
      end
      do_xfer(t, (sel == 2) ? 8'd1 : 8'd0, wl, 16'h0, mp_tab[$urandom_range(0, 3)], base,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 4)) - 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
